// File: rtl/mem_arbiter_if.sv
// Bus bundle between the instruction/data cache miss logic, the memory arbiter and memory.
// slave is the arbiter side; master is the cache/memory side.
interface mem_arbiter_if;
    logic        ic_req;
    logic [15:0] ic_addr;
    logic        dc_req;
    logic [15:0] dc_addr;
    logic        dc_we;
    logic [15:0] dc_wdata;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_valid;
    logic        fill_ic;
    logic        fill_dc;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        ic_done;
    logic        dc_done;
    logic        busy;

    modport slave (
        input  ic_req, ic_addr, dc_req, dc_addr, dc_we, dc_wdata, mem_rdata, mem_valid,
        output mem_en, mem_wr, mem_addr, mem_wdata, fill_ic, fill_dc, fill_word, fill_data,
               ic_done, dc_done, busy
    );

    modport master (
        output ic_req, ic_addr, dc_req, dc_addr, dc_we, dc_wdata, mem_rdata, mem_valid,
        input  mem_en, mem_wr, mem_addr, mem_wdata, fill_ic, fill_dc, fill_word, fill_data,
               ic_done, dc_done, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-cache fills, data-cache fills and data write-throughs onto one memory port.
// Data side wins ties; fills are 8-word bursts; a write waits MEM_LAT cycles before completing.
module mem_arbiter #(
    parameter int MEM_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        IC_FILL  = 3'd1,
        DC_FILL  = 3'd2,
        DC_WRITE = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] addr_r;
    logic [15:0] wdata_r;
    logic        srv_dc_r;
    logic [2:0]  iss_r;
    logic        iss_done_r;
    logic [3:0]  rcv_r;
    logic [3:0]  wcnt_r;
    logic        in_fill_s;
    logic        grant_s;

    logic        mem_en_s;
    logic        mem_wr_s;
    logic [15:0] mem_addr_s;
    logic [15:0] mem_wdata_s;
    logic        ic_done_s;
    logic        dc_done_s;

    assign in_fill_s = (state_r == IC_FILL) || (state_r == DC_FILL);
    assign grant_s   = (state_r == IDLE) && (state_nxt_s != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a fill ends on the 8th returned word regardless of gaps
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.dc_req) begin
                    state_nxt_s = bus.dc_we ? DC_WRITE : DC_FILL;
                end else if (bus.ic_req) begin
                    state_nxt_s = IC_FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            IC_FILL, DC_FILL: begin
                if (bus.mem_valid && (rcv_r == 4'd7)) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            DC_WRITE: begin
                if (wcnt_r == LAT) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = DC_WRITE;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Request latch and issue/receive/wait counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r     <= 16'd0;
            wdata_r    <= 16'd0;
            srv_dc_r   <= 1'b0;
            iss_r      <= 3'd0;
            iss_done_r <= 1'b0;
            rcv_r      <= 4'd0;
            wcnt_r     <= 4'd0;
        end else if (grant_s) begin
            addr_r     <= bus.dc_req ? bus.dc_addr : bus.ic_addr;
            wdata_r    <= bus.dc_wdata;
            srv_dc_r   <= bus.dc_req;
            iss_r      <= 3'd0;
            iss_done_r <= 1'b0;
            rcv_r      <= 4'd0;
            wcnt_r     <= 4'd0;
        end else if (in_fill_s) begin
            if (!iss_done_r) begin
                iss_r      <= iss_r + 3'd1;
                iss_done_r <= (iss_r == 3'd7);
            end
            if (bus.mem_valid) begin
                rcv_r <= rcv_r + 4'd1;
            end
        end else if (state_r == DC_WRITE) begin
            wcnt_r <= wcnt_r + 4'd1;
        end
    end

    // Output decode from registered state only
    always_comb begin
        mem_en_s    = 1'b0;
        mem_wr_s    = 1'b0;
        mem_addr_s  = 16'd0;
        mem_wdata_s = 16'd0;
        ic_done_s   = 1'b0;
        dc_done_s   = 1'b0;
        case (state_r)
            IC_FILL, DC_FILL: begin
                if (!iss_done_r) begin
                    mem_en_s   = 1'b1;
                    mem_addr_s = {addr_r[15:4], iss_r, 1'b0};
                end else begin
                    mem_en_s   = 1'b0;
                end
            end
            DC_WRITE: begin
                if (wcnt_r == 4'd0) begin
                    mem_en_s    = 1'b1;
                    mem_wr_s    = 1'b1;
                    mem_addr_s  = addr_r;
                    mem_wdata_s = wdata_r;
                end else begin
                    mem_en_s    = 1'b0;
                end
            end
            DONE: begin
                ic_done_s = !srv_dc_r;
                dc_done_s = srv_dc_r;
            end
            default: begin
                mem_en_s = 1'b0;
            end
        endcase
    end

    assign bus.mem_en    = mem_en_s;
    assign bus.mem_wr    = mem_wr_s;
    assign bus.mem_addr  = mem_addr_s;
    assign bus.mem_wdata = mem_wdata_s;
    assign bus.ic_done   = ic_done_s;
    assign bus.dc_done   = dc_done_s;
    assign bus.busy      = (state_r != IDLE);
    assign bus.fill_word = rcv_r[2:0];
    assign bus.fill_ic   = bus.mem_valid && (state_r == IC_FILL);
    assign bus.fill_dc   = bus.mem_valid && (state_r == DC_FILL);
    assign bus.fill_data = bus.mem_rdata;

endmodule
